// File: rtl/rename_register_file_pkg.sv
// Shared defaults and types for the rename register file and its read ports.
package rf_pkg;

    localparam int unsigned XLEN_DEFAULT  = 32;
    localparam int unsigned TAG_W_DEFAULT = 5;
    localparam int unsigned NREG_DEFAULT  = 32;
    localparam int unsigned REG_ZERO      = 0;

    typedef struct packed {
        logic                     busy;
        logic [TAG_W_DEFAULT-1:0] tag;
    } rf_entry_t;

endpackage

// File: rtl/rf_read_port.sv
// One operand lookup port: architectural state plus same-cycle commit bypass.
module rf_read_port
    import rf_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEFAULT,
    parameter int unsigned NREG  = NREG_DEFAULT,
    parameter int unsigned TAG_W = TAG_W_DEFAULT,
    parameter int unsigned NCM   = 2,
    localparam int unsigned REG_W = $clog2(NREG)
) (
    input  logic [REG_W-1:0]      ask_reg,
    input  logic [NREG-1:0]       reg_busy,
    input  logic [TAG_W-1:0]      reg_tag   [NREG],
    input  logic [XLEN-1:0]       reg_value [NREG],
    input  logic [NCM-1:0]        commit_valid,
    input  logic [NCM*REG_W-1:0]  commit_reg,
    input  logic [NCM*TAG_W-1:0]  commit_tag,
    input  logic [NCM*XLEN-1:0]   commit_value,
    output logic                  ask_busy,
    output logic [TAG_W-1:0]      ask_tag,
    output logic [XLEN-1:0]       ask_value
);

    always_comb begin
        ask_busy  = reg_busy[ask_reg];
        ask_tag   = reg_tag[ask_reg];
        ask_value = reg_value[ask_reg];
        // Ascending scan so the youngest matching commit port wins.
        for (int unsigned k = 0; k < NCM; k++) begin
            if (commit_valid[k] &&
                commit_reg[k*REG_W +: REG_W] == ask_reg &&
                reg_busy[ask_reg] &&
                commit_tag[k*TAG_W +: TAG_W] == reg_tag[ask_reg]) begin
                ask_busy  = 1'b0;
                ask_value = commit_value[k*XLEN +: XLEN];
            end
        end
        if (ask_reg == REG_W'(REG_ZERO)) begin
            ask_busy  = 1'b0;
            ask_tag   = '0;
            ask_value = '0;
        end
    end

endmodule

// File: rtl/rename_register_file.sv
// Architectural register file with rename tags, multi-port commit and wakeup broadcast.
module rename_register_file
    import rf_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEFAULT,
    parameter int unsigned NREG  = NREG_DEFAULT,
    parameter int unsigned TAG_W = TAG_W_DEFAULT,
    parameter int unsigned NRD   = 2,
    parameter int unsigned NCM   = 2,
    localparam int unsigned REG_W = $clog2(NREG)
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  clear_in,
    input  logic                  launch_valid,
    input  logic [REG_W-1:0]      launch_reg,
    input  logic [TAG_W-1:0]      launch_tag,
    input  logic [NCM-1:0]        commit_valid,
    input  logic [NCM*REG_W-1:0]  commit_reg,
    input  logic [NCM*TAG_W-1:0]  commit_tag,
    input  logic [NCM*XLEN-1:0]   commit_value,
    input  logic [NRD*REG_W-1:0]  ask_reg,
    output logic [NRD-1:0]        ask_busy,
    output logic [NRD*TAG_W-1:0]  ask_tag,
    output logic [NRD*XLEN-1:0]   ask_value,
    output logic [NCM-1:0]        bc_valid,
    output logic [NCM*TAG_W-1:0]  bc_tag,
    output logic [NCM*XLEN-1:0]   bc_value
);

    typedef struct packed {
        logic             busy;
        logic [TAG_W-1:0] tag;
    } entry_t;

    entry_t          entry_q [NREG];
    entry_t          entry_d [NREG];
    logic [XLEN-1:0] value_q [NREG];
    logic [XLEN-1:0] value_d [NREG];
    logic [NREG-1:0] clear_hit;
    logic [NREG-1:0] busy_vec;
    logic [TAG_W-1:0] tag_arr [NREG];

    always_comb begin
        for (int unsigned i = 0; i < NREG; i++) begin
            busy_vec[i] = entry_q[i].busy;
            tag_arr[i]  = entry_q[i].tag;
        end
    end

    always_comb begin
        value_d   = value_q;
        entry_d   = entry_q;
        clear_hit = '0;
        // Ascending scan: the youngest port's value lands last; any tag match clears busy.
        for (int unsigned k = 0; k < NCM; k++) begin
            if (commit_valid[k] && commit_reg[k*REG_W +: REG_W] != REG_W'(REG_ZERO)) begin
                value_d[commit_reg[k*REG_W +: REG_W]] = commit_value[k*XLEN +: XLEN];
                if (entry_q[commit_reg[k*REG_W +: REG_W]].busy &&
                    entry_q[commit_reg[k*REG_W +: REG_W]].tag == commit_tag[k*TAG_W +: TAG_W]) begin
                    clear_hit[commit_reg[k*REG_W +: REG_W]] = 1'b1;
                end
            end
        end
        for (int unsigned i = 0; i < NREG; i++) begin
            if (clear_hit[i]) begin
                entry_d[i].busy = 1'b0;
            end
        end
        if (launch_valid && !clear_in && launch_reg != REG_W'(REG_ZERO)) begin
            entry_d[launch_reg].busy = 1'b1;
            entry_d[launch_reg].tag  = launch_tag;
        end
        if (clear_in) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                entry_d[i].busy = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                entry_q[i] <= '0;
                value_q[i] <= '0;
            end
            bc_valid <= '0;
            bc_tag   <= '0;
            bc_value <= '0;
        end else if (rdy_in) begin
            entry_q  <= entry_d;
            value_q  <= value_d;
            bc_valid <= clear_in ? '0 : commit_valid;
            bc_tag   <= commit_tag;
            bc_value <= commit_value;
        end
    end

    for (genvar j = 0; j < NRD; j++) begin : g_rd
        rf_read_port #(
            .XLEN  (XLEN),
            .NREG  (NREG),
            .TAG_W (TAG_W),
            .NCM   (NCM)
        ) u_rd (
            .ask_reg      (ask_reg[j*REG_W +: REG_W]),
            .reg_busy     (busy_vec),
            .reg_tag      (tag_arr),
            .reg_value    (value_q),
            .commit_valid (commit_valid),
            .commit_reg   (commit_reg),
            .commit_tag   (commit_tag),
            .commit_value (commit_value),
            .ask_busy     (ask_busy[j]),
            .ask_tag      (ask_tag[j*TAG_W +: TAG_W]),
            .ask_value    (ask_value[j*XLEN +: XLEN])
        );
    end

endmodule

// File: tb/tb_rename_register_file.sv
// Directed and randomized checks of rename_register_file against a behavioural model.
module tb_rename_register_file;

    localparam int XL = 32;
    localparam int NR = 32;
    localparam int RW = 5;
    localparam int TW = 5;
    localparam int RD = 2;
    localparam int CM = 2;

    logic              clk_in;
    logic              rst_in;
    logic              rdy_in;
    logic              clear_in;
    logic              launch_valid;
    logic [RW-1:0]     launch_reg;
    logic [TW-1:0]     launch_tag;
    logic [CM-1:0]     commit_valid;
    logic [CM*RW-1:0]  commit_reg;
    logic [CM*TW-1:0]  commit_tag;
    logic [CM*XL-1:0]  commit_value;
    logic [RD*RW-1:0]  ask_reg;
    logic [RD-1:0]     ask_busy;
    logic [RD*TW-1:0]  ask_tag;
    logic [RD*XL-1:0]  ask_value;
    logic [CM-1:0]     bc_valid;
    logic [CM*TW-1:0]  bc_tag;
    logic [CM*XL-1:0]  bc_value;

    rename_register_file #(
        .XLEN  (XL),
        .NREG  (NR),
        .TAG_W (TW),
        .NRD   (RD),
        .NCM   (CM)
    ) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .rdy_in       (rdy_in),
        .clear_in     (clear_in),
        .launch_valid (launch_valid),
        .launch_reg   (launch_reg),
        .launch_tag   (launch_tag),
        .commit_valid (commit_valid),
        .commit_reg   (commit_reg),
        .commit_tag   (commit_tag),
        .commit_value (commit_value),
        .ask_reg      (ask_reg),
        .ask_busy     (ask_busy),
        .ask_tag      (ask_tag),
        .ask_value    (ask_value),
        .bc_valid     (bc_valid),
        .bc_tag       (bc_tag),
        .bc_value     (bc_value)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Reference state: what each architectural register holds, plus the last broadcast.
    logic [XL-1:0] m_val  [NR];
    logic          m_busy [NR];
    logic [TW-1:0] m_tag  [NR];
    logic [CM-1:0] m_bcv;
    logic [TW-1:0] m_bct [CM];
    logic [XL-1:0] m_bcd [CM];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [RW-1:0] c_reg(input int k);
        return commit_reg[k*RW +: RW];
    endfunction

    function automatic void model_read(input logic [RW-1:0] r, output logic eb,
                                       output logic [TW-1:0] et, output logic [XL-1:0] ev);
        eb = 1'b0; et = '0; ev = '0;
        if (r != 0) begin
            eb = m_busy[r]; et = m_tag[r]; ev = m_val[r];
            for (int k = 0; k < CM; k++)
                if (commit_valid[k] && c_reg(k) == r && m_busy[r] && commit_tag[k*TW +: TW] == m_tag[r]) begin
                    eb = 1'b0;
                    ev = commit_value[k*XL +: XL];
                end
        end
    endfunction

    task automatic model_edge();
        logic hit [NR];
        if (rst_in) begin
            for (int i = 0; i < NR; i++) begin
                m_val[i] = '0; m_busy[i] = 1'b0; m_tag[i] = '0;
            end
            m_bcv = '0;
            for (int k = 0; k < CM; k++) begin
                m_bct[k] = '0; m_bcd[k] = '0;
            end
        end else if (rdy_in) begin
            for (int i = 0; i < NR; i++) hit[i] = 1'b0;
            for (int k = 0; k < CM; k++)
                if (commit_valid[k] && c_reg(k) != 0) begin
                    if (m_busy[c_reg(k)] && m_tag[c_reg(k)] == commit_tag[k*TW +: TW]) hit[c_reg(k)] = 1'b1;
                    m_val[c_reg(k)] = commit_value[k*XL +: XL];
                end
            for (int i = 0; i < NR; i++) if (hit[i]) m_busy[i] = 1'b0;
            if (launch_valid && !clear_in && launch_reg != 0) begin
                m_busy[launch_reg] = 1'b1;
                m_tag[launch_reg]  = launch_tag;
            end
            if (clear_in) for (int i = 0; i < NR; i++) m_busy[i] = 1'b0;
            m_bcv = clear_in ? '0 : commit_valid;
            for (int k = 0; k < CM; k++) begin
                m_bct[k] = commit_tag[k*TW +: TW];
                m_bcd[k] = commit_value[k*XL +: XL];
            end
        end
    endtask

    task automatic compare_outputs();
        logic eb; logic [TW-1:0] et; logic [XL-1:0] ev;
        for (int j = 0; j < RD; j++) begin
            model_read(ask_reg[j*RW +: RW], eb, et, ev);
            chk($sformatf("ask_busy%0d", j), 32'(ask_busy[j]), 32'(eb));
            if (eb) chk($sformatf("ask_tag%0d", j), 32'(ask_tag[j*TW +: TW]), 32'(et));
            else    chk($sformatf("ask_value%0d", j), ask_value[j*XL +: XL], ev);
        end
        for (int k = 0; k < CM; k++) begin
            chk($sformatf("bc_valid%0d", k), 32'(bc_valid[k]), 32'(m_bcv[k]));
            chk($sformatf("bc_tag%0d", k), 32'(bc_tag[k*TW +: TW]), 32'(m_bct[k]));
            chk($sformatf("bc_value%0d", k), bc_value[k*XL +: XL], m_bcd[k]);
        end
    endtask

    task automatic step();
        #1 compare_outputs();
        @(posedge clk_in);
        model_edge();
        @(negedge clk_in);
    endtask

    task automatic idle();
        rst_in = 1'b0; rdy_in = 1'b1; clear_in = 1'b0;
        launch_valid = 1'b0; launch_reg = '0; launch_tag = '0;
        commit_valid = '0; commit_reg = '0; commit_tag = '0; commit_value = '0;
        ask_reg = '0;
    endtask

    task automatic launch(input int r, input int t);
        launch_valid = 1'b1; launch_reg = RW'(r); launch_tag = TW'(t);
    endtask

    task automatic commit(input int k, input int r, input int t, input logic [XL-1:0] v);
        commit_valid[k] = 1'b1;
        commit_reg[k*RW +: RW] = RW'(r);
        commit_tag[k*TW +: TW] = TW'(t);
        commit_value[k*XL +: XL] = v;
    endtask

    task automatic ask(input int j, input int r);
        ask_reg[j*RW +: RW] = RW'(r);
    endtask

    initial begin
        idle();
        rst_in = 1'b1;
        @(posedge clk_in);
        model_edge();
        @(negedge clk_in);

        // Reset then read
        idle(); ask(0, 5); ask(1, 0);
        #1;
        chk("rst_busy", 32'(ask_busy), 32'b00);
        chk("rst_val5", ask_value[31:0], 32'h0);
        chk("rst_val0", ask_value[63:32], 32'h0);
        chk("rst_bcv", 32'(bc_valid), 32'b00);
        step();

        // Launch then matching commit with bypass
        idle(); launch(5, 3); step();
        idle(); ask(0, 5);
        #1 chk("l5_busy", 32'(ask_busy[0]), 32'd1);
        chk("l5_tag", 32'(ask_tag[4:0]), 32'd3);
        step();
        idle(); ask(0, 5); commit(0, 5, 3, 32'hDEAD);
        #1 chk("byp_busy", 32'(ask_busy[0]), 32'd0);
        chk("byp_val", ask_value[31:0], 32'hDEAD);
        step();
        idle(); ask(0, 5);
        #1 chk("st5_busy", 32'(ask_busy[0]), 32'd0);
        chk("st5_val", ask_value[31:0], 32'hDEAD);
        chk("bc0_v", 32'(bc_valid), 32'b01);
        chk("bc0_tag", 32'(bc_tag[4:0]), 32'd3);
        chk("bc0_val", bc_value[31:0], 32'hDEAD);
        step();

        // Stale commit
        idle(); launch(7, 2); step();
        idle(); launch(7, 9); step();
        idle(); commit(0, 7, 2, 32'h11); ask(0, 7);
        #1 chk("stale_byp", 32'(ask_busy[0]), 32'd1);
        step();
        idle(); ask(0, 7);
        #1 chk("stale_busy", 32'(ask_busy[0]), 32'd1);
        chk("stale_tag", 32'(ask_tag[4:0]), 32'd9);
        step();

        // Dual commit to one register
        idle(); launch(4, 6); step();
        idle(); commit(0, 4, 1, 32'hA); commit(1, 4, 6, 32'hB); step();
        idle(); ask(0, 4);
        #1 chk("dual_busy", 32'(ask_busy[0]), 32'd0);
        chk("dual_val", ask_value[31:0], 32'hB);
        step();

        // Same-cycle launch and commit
        idle(); launch(8, 10); step();
        idle(); launch(8, 12); commit(0, 8, 10, 32'h77); step();
        idle(); ask(0, 8);
        #1 chk("lc_busy", 32'(ask_busy[0]), 32'd1);
        chk("lc_tag", 32'(ask_tag[4:0]), 32'd12);
        step();
        idle(); commit(0, 8, 12, 32'h99); step();

        // Clear with concurrent commit
        idle(); launch(1, 1); step();
        idle(); launch(2, 2); step();
        idle(); launch(3, 3); step();
        idle(); clear_in = 1'b1; launch(6, 6); commit(0, 1, 1, 32'h55); step();
        idle(); ask(0, 1); ask(1, 2);
        #1 chk("clr_busy", 32'(ask_busy), 32'b00);
        chk("clr_val1", ask_value[31:0], 32'h55);
        chk("clr_bcv", 32'(bc_valid), 32'b00);
        step();
        idle(); ask(0, 3); ask(1, 6);
        #1 chk("clr_busy36", 32'(ask_busy), 32'b00);
        step();

        // rdy_in low freezes state and broadcast
        idle(); commit(1, 10, 0, 32'h1234); step();
        idle(); rdy_in = 1'b0; launch(9, 4); step();
        idle(); ask(0, 9);
        #1 chk("rdy_busy", 32'(ask_busy[0]), 32'd0);
        chk("rdy_bcv", 32'(bc_valid), 32'b10);
        chk("rdy_bcval", bc_value[63:32], 32'h1234);
        step();

        // Randomized traffic with register/tag collisions
        for (int n = 0; n < 1500; n++) begin
            idle();
            rst_in   = ($urandom_range(0, 99) == 0);
            rdy_in   = ($urandom_range(0, 9) != 0);
            clear_in = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 1) == 1) launch($urandom_range(0, 11), $urandom_range(0, 31));
            for (int k = 0; k < CM; k++) begin
                if ($urandom_range(0, 2) != 0) begin
                    int r;
                    r = (k > 0 && $urandom_range(0, 3) == 0) ? int'(c_reg(0)) : $urandom_range(0, 11);
                    commit(k, r, ($urandom_range(0, 2) != 0) ? int'(m_tag[r]) : $urandom_range(0, 31),
                           $urandom());
                end
            end
            for (int j = 0; j < RD; j++)
                ask(j, ($urandom_range(0, 1) == 1) ? int'(c_reg(j % CM)) : $urandom_range(0, 11));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rename_register_file.md
Name: rename_register_file

Overview:
Parametrised successor to the single-commit architectural register file with rename tags. Holds NREG architectural registers, each with a busy bit and the ROB tag of its youngest in-flight producer. Supports NCM commit ports per cycle, NRD combinational read ports with same-cycle commit bypass, and one registered broadcast channel per commit port to the ReservationStation. Sits between ROB (launch/commit), Decoder (operand lookup) and ReservationStation (wakeup).

Parameters:
XLEN, 32, data width
NREG, 32, architectural register count, power of two; register 0 hardwired zero
REG_W, $clog2(NREG), register index width (derived, not overridable)
TAG_W, 5, ROB tag width; any tag value is legal, because busy is a separate bit
NRD, 2, read (ask) ports
NCM, 2, commit ports; a higher port index is younger in program order

Ports:
clk_in  input  1  system clock
rst_in  input  1  synchronous active-high reset
rdy_in  input  1  global enable; low freezes all state
clear_in  input  1  pipeline flush
launch_valid  input  1  ROB launch strobe
launch_reg  input  REG_W  destination register of launched instruction
launch_tag  input  TAG_W  ROB tag of launched instruction
commit_valid  input  NCM  per-port commit strobe
commit_reg  input  NCM*REG_W  packed destination registers
commit_tag  input  NCM*TAG_W  packed committing tags
commit_value  input  NCM*XLEN  packed committed values
ask_reg  input  NRD*REG_W  packed read indices
ask_busy  output  NRD  operand still pending
ask_tag  output  NRD*TAG_W  producer tag; valid only when busy
ask_value  output  NRD*XLEN  operand value; valid only when not busy
bc_valid  output  NCM  registered broadcast strobe per commit port
bc_tag  output  NCM*TAG_W  broadcast tag
bc_value  output  NCM*XLEN  broadcast value

Behaviour:
- Reset, when rst_in is high at a clock edge:
  - all values, busy bits and tags go to 0;
  - bc_valid, bc_tag and bc_value go to 0.
  - Reset overrides rdy_in and every other input.
- rdy_in low: no state changes and bc_* hold their values. Reads remain combinational.
- Any write, launch or commit, targeting register 0 is ignored. Reads of register 0 always return busy=0, value=0.
- Launch: at the edge, busy[launch_reg] is set to 1 and tag[launch_reg] to launch_tag.
- Commit, for each port k with commit_valid[k] set:
  - value[commit_reg[k]] is written with commit_value[k];
  - busy[commit_reg[k]] is cleared only if the register is busy, its tag equals commit_tag[k], and no same-cycle launch targets the same register. A launch wins over a commit clear.
- Two commit ports writing the same register in one cycle:
  - the higher port index wins the value;
  - busy is cleared if either port's tag matches the stored tag.
- Broadcast:
  - bc_valid[k] is registered from commit_valid[k], one cycle of latency;
  - bc_tag and bc_value are registered from the commit inputs;
  - commits to register 0 broadcast normally, so wakeup does not depend on the destination;
  - bc_valid[k] is deasserted in cycles with no commit on port k.
- Clear:
  - all busy bits go to 0 and the launch in the same cycle is discarded;
  - commits in the same cycle still write values, because commits are architectural;
  - bc_valid is forced to 0 for that cycle's commits.
- Reads, combinational for each port j:
  - base case: busy, tag and value are taken from state;
  - bypass: if a valid commit port targets ask_reg[j], the register is busy, and the commit tag matches the stored tag, then ask_busy=0 and ask_value is that commit value. The highest matching port wins.
  - a same-cycle launch is not visible to reads; the Decoder resolves intra-group dependencies.
- Latency:
  - state updates are visible to reads at the next cycle;
  - a commit is visible the same cycle through the bypass;
  - wakeup reaches the ReservationStation one cycle after commit.

Decomposition:
- Shared package rf_pkg holds:
  - the defaults for XLEN, TAG_W and NREG;
  - the localparam REG_ZERO=0;
  - a typedef for the per-register entry {busy, tag}.
- One natural sub-module, rf_read_port, instantiated NRD times. It covers lookup plus the NCM-wide bypass priority mux.
- Commit and launch update logic stays in the top level.

Test Plan:
- Reset then read: rst_in=1 for one cycle, then ask_reg={5,0} -> ask_busy=00, ask_value=0,0 and bc_valid=00.
- Launch then matching commit:
  - cycle 0: launch reg 5, tag 3 -> next cycle ask reg 5 gives busy=1, tag=3;
  - cycle 2: commit port0 reg 5, tag 3, value 0xDEAD -> the same cycle read gives busy=0, value=0xDEAD through the bypass;
  - next cycle: busy=0 from state, and bc_valid[0]=1 with tag 3, value 0xDEAD.
- Stale commit:
  - launch reg 7 with tag 2, then launch reg 7 with tag 9;
  - commit reg 7 with tag 2, value 0x11 -> value is written, busy stays 1, tag stays 9.
- Dual commit to the same register: port0 reg 4 tag 1 value 0xA and port1 reg 4 tag 6 value 0xB, with stored tag 6 -> value becomes 0xB and busy is cleared.
- Same-cycle launch and commit: launch reg 8 tag 12 together with commit reg 8 tag 10 (stored tag 10) -> busy=1, tag=12, value updated.
- Clear and rdy_in:
  - clear_in=1 with busy registers 1, 2, 3 and commit reg 1 value 0x55 -> all busy bits 0, reg1=0x55, bc_valid=00;
  - rdy_in=0 during a launch -> no state change and bc_* hold.
